// File: rtl/link_serial_responder.sv
// Pocket link-port responder: shifts one byte out on SO and in from SI per
// 8 externally driven SCK pulses, MSB first, with a valid/ready TX side.

package pocket;
  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_e;
endpackage

module link_serial_responder
  import pocket::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter logic [7:0]  IDLE_BYTE      = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       sck_in,
  input  logic       si_in,
  output logic       so_out,
  output dir_e       so_dir,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       underrun,
  output logic       timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [7:0]             sr_q, sr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   so_q, so_d;
  dir_e                   dir_q, dir_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   timeout_q, timeout_d;

  logic       sck_s, si_s, sck_rise, sck_fall;
  logic [7:0] shifted, idle_shifted;

  assign sck_s        = sck_sync_q[SYNC_STAGES-1];
  assign si_s         = si_sync_q[SYNC_STAGES-1];
  assign sck_rise     = sck_s & ~sck_prev_q;
  assign sck_fall     = ~sck_s & sck_prev_q;
  assign shifted      = {sr_q[6:0], si_s};
  assign idle_shifted = {IDLE_BYTE[6:0], si_s};

  // Next-state, shift and strobe logic
  always_comb begin
    state_d    = state_q;
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck_in};
    si_sync_d  = {si_sync_q[SYNC_STAGES-2:0], si_in};
    sck_prev_d = sck_s;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    so_d       = so_q;
    dir_d      = enable ? DIR_OUT : DIR_IN;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    timeout_d  = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      so_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A detected rise beats a simultaneous TX offer
          if (sck_rise) begin
            sr_d       = idle_shifted;
            cnt_d      = 4'd1;
            state_d    = ST_SHIFT;
            underrun_d = 1'b1;
          end else if (tx_valid) begin
            sr_d    = tx_data;
            so_d    = tx_data[7];
            cnt_d   = 4'd0;
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (sck_rise) begin
            sr_d    = shifted;
            cnt_d   = 4'd1;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            sr_d = shifted;
            if (cnt_q == 4'd7) begin
              rx_data_d  = shifted;
              rx_valid_d = 1'b1;
              cnt_d      = 4'd0;
              so_d       = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (sck_fall) begin
            so_d = sr_q[7];
          end else if (tmo_q == TMO_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = 4'd0;
            so_d      = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          so_d    = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers; SCK sync resets to its idle-high level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sck_sync_q <= '1;
      si_sync_q  <= '0;
      sck_prev_q <= 1'b1;
      sr_q       <= 8'h00;
      cnt_q      <= 4'd0;
      tmo_q      <= '0;
      so_q       <= 1'b1;
      dir_q      <= DIR_IN;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_sync_q <= sck_sync_d;
      si_sync_q  <= si_sync_d;
      sck_prev_q <= sck_prev_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      so_q       <= so_d;
      dir_q      <= dir_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign so_out   = so_q;
  assign so_dir   = dir_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != ST_IDLE);
  // Held low while in reset so the handshake never advertises readiness then
  assign tx_ready = reset_n & enable & (state_q == ST_IDLE);

endmodule

// File: tb/tb_link_serial_responder.sv
// Directed bench for link_serial_responder with hand-computed expectations.

module tb_link_serial_responder;
  import pocket::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       sck_in;
  logic       si_in;
  logic       so_out;
  dir_e       so_dir;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       underrun;
  logic       timeout;

  link_serial_responder #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(32),
    .IDLE_BYTE     (8'hFF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .sck_in  (sck_in),
    .si_in   (si_in),
    .so_out  (so_out),
    .so_dir  (so_dir),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .underrun(underrun),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int und_cnt  = 0;
  int tmo_cnt  = 0;
  int multi_cnt = 0;

  // Strobe counters, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (underrun === 1'b1) und_cnt++;
    if (timeout === 1'b1) tmo_cnt++;
    if ((32'(rx_valid) + 32'(underrun) + 32'(timeout)) > 32'd1) multi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_set(input logic lvl, input logic si_b);
    @(negedge clk);
    sck_in = lvl;
    si_in  = si_b;
  endtask

  // One SCK pulse (fall then rise); SO is sampled just before the pin rise
  task automatic pulse(input logic si_b, input int tail, output logic so_seen);
    sck_set(1'b0, si_b);
    wait_cyc(9);
    so_seen = so_out;
    sck_set(1'b1, si_b);
    wait_cyc(tail);
  endtask

  task automatic send_byte(input logic [7:0] si_b, output logic [7:0] so_b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      pulse(si_b[i], 9, s);
      so_b[i] = s;
    end
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] sob;
    logic       s;
    int         rx0, und0, tmo0;

    reset_n  = 1'b0;
    enable   = 1'b1;
    sck_in   = 1'b1;
    si_in    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    wait_cyc(3);

    // Reset values
    check("rst_so_out", 32'(so_out), 32'd1);
    check("rst_so_dir", 32'(so_dir), 32'(DIR_IN));
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_strobes", {29'd0, rx_valid, underrun, timeout}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    wait_cyc(2);
    check("idle_so_dir", 32'(so_dir), 32'(DIR_OUT));
    check("idle_tx_ready", 32'(tx_ready), 32'd1);

    // 1: load A5, receive 3C
    rx0 = rx_cnt; und0 = und_cnt;
    load(8'hA5);
    check("t1_busy_after_load", 32'(busy), 32'd1);
    check("t1_so_msb", 32'(so_out), 32'd1);
    check("t1_tx_ready_armed", 32'(tx_ready), 32'd0);
    for (int i = 7; i >= 1; i--) begin
      pulse(1'(8'h3C >> i), 9, s);
      sob[i] = s;
    end
    pulse(1'b0, 2, s);
    sob[0] = s;
    check("t1_rx_valid_early", 32'(rx_valid), 32'd0);
    wait_cyc(1);
    check("t1_rx_valid", 32'(rx_valid), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'h3C);
    check("t1_tx_ready_after", 32'(tx_ready), 32'd1);
    check("t1_so_released", 32'(so_out), 32'd1);
    wait_cyc(1);
    check("t1_rx_valid_one_cycle", 32'(rx_valid), 32'd0);
    check("t1_so_bits", 32'(sob), 32'hA5);
    check("t1_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("t1_no_underrun", 32'(und_cnt - und0), 32'd0);
    wait_cyc(8);

    // 2: underrun, nothing loaded, SI all zeros
    rx0 = rx_cnt; und0 = und_cnt;
    send_byte(8'h00, sob);
    check("t2_so_all_ones", 32'(sob), 32'hFF);
    check("t2_underrun_count", 32'(und_cnt - und0), 32'd1);
    check("t2_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("t2_rx_data", 32'(rx_data), 32'h00);

    // 3: ARMED never times out; SHIFT times out after 3 pulses
    rx0 = rx_cnt; tmo0 = tmo_cnt;
    load(8'h81);
    wait_cyc(60);
    check("t3_armed_busy", 32'(busy), 32'd1);
    check("t3_armed_no_timeout", 32'(tmo_cnt - tmo0), 32'd0);
    pulse(1'b1, 9, s); sob[2] = s;
    pulse(1'b0, 9, s); sob[1] = s;
    pulse(1'b1, 9, s); sob[0] = s;
    check("t3_so_bits", {29'd0, sob[2:0]}, 32'd4);
    wait_cyc(10);
    check("t3_busy_before_timeout", 32'(busy), 32'd1);
    check("t3_no_early_timeout", 32'(tmo_cnt - tmo0), 32'd0);
    wait_cyc(40);
    check("t3_timeout_count", 32'(tmo_cnt - tmo0), 32'd1);
    check("t3_no_rx_valid", 32'(rx_cnt - rx0), 32'd0);
    check("t3_tx_ready", 32'(tx_ready), 32'd1);
    check("t3_so_out", 32'(so_out), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);

    // 4: tx_valid coincides with the IDLE rise; rise wins
    rx0 = rx_cnt; und0 = und_cnt;
    sck_set(1'b0, 1'b1);
    wait_cyc(9);
    sob[7] = so_out;
    sck_set(1'b1, 1'b1);
    wait_cyc(2);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
    check("t4_underrun", 32'(underrun), 32'd1);
    check("t4_tx_ready_low", 32'(tx_ready), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    wait_cyc(6);
    for (int i = 6; i >= 0; i--) begin
      pulse(1'(8'hE1 >> i), 9, s);
      sob[i] = s;
      if (i == 3) check("t4_tx_ready_mid", 32'(tx_ready), 32'd0);
    end
    check("t4_so_idle_byte", 32'(sob), 32'hFF);
    check("t4_rx_data", 32'(rx_data), 32'hE1);
    check("t4_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("t4_underrun_count", 32'(und_cnt - und0), 32'd1);
    check("t4_tx_ready_end", 32'(tx_ready), 32'd1);

    // 5a: enable dropped for one cycle mid-byte
    rx0 = rx_cnt; und0 = und_cnt; tmo0 = tmo_cnt;
    load(8'hC3);
    for (int i = 0; i < 3; i++) pulse(1'b1, 9, s);
    @(negedge clk);
    enable = 1'b0;
    wait_cyc(1);
    check("t5_dir_in", 32'(so_dir), 32'(DIR_IN));
    check("t5_busy_off", 32'(busy), 32'd0);
    check("t5_so_released", 32'(so_out), 32'd1);
    check("t5_tx_ready_disabled", 32'(tx_ready), 32'd0);
    enable = 1'b1;
    wait_cyc(1);
    check("t5_dir_out", 32'(so_dir), 32'(DIR_OUT));
    check("t5_tx_ready_back", 32'(tx_ready), 32'd1);
    wait_cyc(40);
    check("t5_no_strobes", 32'((rx_cnt - rx0) + (und_cnt - und0) + (tmo_cnt - tmo0)), 32'd0);
    check("t5_rx_data_held", 32'(rx_data), 32'hE1);

    // 5b: reset pulse mid-byte
    load(8'h0F);
    pulse(1'b1, 9, s);
    pulse(1'b0, 9, s);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_rst_so_out", 32'(so_out), 32'd1);
    check("t5_rst_so_dir", 32'(so_dir), 32'(DIR_IN));
    check("t5_rst_tx_ready", 32'(tx_ready), 32'd0);
    check("t5_rst_rx_data", 32'(rx_data), 32'h00);
    check("t5_rst_strobes", {29'd0, rx_valid, underrun, timeout}, 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(2);

    // 6: back-to-back bytes, second loaded as tx_ready rises
    rx0 = rx_cnt; und0 = und_cnt;
    load(8'h3C);
    for (int i = 7; i >= 1; i--) begin
      pulse(1'(8'h96 >> i), 9, s);
      sob[i] = s;
    end
    pulse(1'b0, 2, s);
    sob[0] = s;
    check("t6_tx_ready_before", 32'(tx_ready), 32'd0);
    wait_cyc(1);
    check("t6_rx_valid_first", 32'(rx_valid), 32'd1);
    check("t6_rx_data_first", 32'(rx_data), 32'h96);
    check("t6_tx_ready_rise", 32'(tx_ready), 32'd1);
    check("t6_so_first", 32'(sob), 32'h3C);
    tx_data  = 8'hC7;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
    check("t6_second_loaded", 32'(busy), 32'd1);
    send_byte(8'h69, sob);
    check("t6_so_second", 32'(sob), 32'hC7);
    check("t6_rx_data_second", 32'(rx_data), 32'h69);
    check("t6_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("t6_no_underrun", 32'(und_cnt - und0), 32'd0);

    check("strobes_exclusive", 32'(multi_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the directed sequence stalls
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
